seg_scan_ctrl: RTL



---
 rtl/seg_scan_if.sv | 22 ++
 rtl/seg_scan_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// Load handshake and display-side signals of the seven-segment scan controller.
interface seg_scan_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        lzs;
  logic        load_ack;
  logic [1:0]  anode_driver;
  logic [6:0]  seg;
  logic        dp;
  logic        digit_strobe;

  modport master (
    output load, value, dp_mask, lzs,
    input  load_ack, anode_driver, seg, dp, digit_strobe
  );

  modport slave (
    input  load, value, dp_mask, lzs,
    output load_ack, anode_driver, seg, dp, digit_strobe
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit seven-segment scan controller; new values are committed only at
// frame boundaries so a frame never mixes old and new digits.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic      clk,
    input  logic      rst_n,
    seg_scan_if.slave bus
);
    localparam int unsigned   PW   = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_anode;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_ack;
    logic          r_strobe;

    logic          r_pend;
    logic [15:0]   r_pend_val;
    logic [3:0]    r_pend_dp;
    logic          r_pend_lzs;

    logic [15:0]   r_sh_val;
    logic [3:0]    r_sh_dp;
    logic          r_sh_lzs;
    logic [3:0]    r_sh_blank;

    logic          w_tick;
    logic          w_commit;
    logic [1:0]    w_next_idx;
    logic [15:0]   w_src_val;
    logic [3:0]    w_src_dp;
    logic          w_src_lzs;
    logic [3:0]    w_src_blank;
    logic [3:0]    w_lz;
    logic [3:0]    w_nib;
    logic [6:0]    w_hex;
    logic [6:0]    w_seg_next;
    logic          w_dp_next;

    assign w_tick     = (r_presc == LAST);
    assign w_commit   = w_tick && (r_anode == 2'd3) && r_pend;
    assign w_next_idx = r_anode + 2'd1;

    // Decode from the contents that will be shadowed after this edge, so the
    // first digit of a freshly committed frame already shows new data.
    assign w_src_val   = w_commit ? r_pend_val : r_sh_val;
    assign w_src_dp    = w_commit ? r_pend_dp  : r_sh_dp;
    assign w_src_lzs   = w_commit ? r_pend_lzs : r_sh_lzs;
    assign w_src_blank = w_commit ? 4'h0       : r_sh_blank;

    always_comb begin
        w_lz    = '0;
        w_lz[3] = w_src_lzs && (w_src_val[15:12] == 4'h0);
        w_lz[2] = w_lz[3] && (w_src_val[11:8] == 4'h0);
        w_lz[1] = w_lz[2] && (w_src_val[7:4] == 4'h0);
        w_nib   = w_src_val[{w_next_idx, 2'b00} +: 4];
        case (w_nib)
            4'h0:    w_hex = 7'h40;
            4'h1:    w_hex = 7'h79;
            4'h2:    w_hex = 7'h24;
            4'h3:    w_hex = 7'h30;
            4'h4:    w_hex = 7'h19;
            4'h5:    w_hex = 7'h12;
            4'h6:    w_hex = 7'h02;
            4'h7:    w_hex = 7'h78;
            4'h8:    w_hex = 7'h00;
            4'h9:    w_hex = 7'h10;
            4'hA:    w_hex = 7'h08;
            4'hB:    w_hex = 7'h03;
            4'hC:    w_hex = 7'h46;
            4'hD:    w_hex = 7'h21;
            4'hE:    w_hex = 7'h06;
            default: w_hex = 7'h0E;
        endcase
        w_seg_next = (w_src_blank[w_next_idx] || w_lz[w_next_idx]) ? 7'h7F : w_hex;
        w_dp_next  = ~w_src_dp[w_next_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc  <= '0;
            r_anode  <= '0;
            r_seg    <= '1;
            r_dp     <= 1'b1;
            r_ack    <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_presc  <= w_tick ? '0 : r_presc + PW'(1);
            r_ack    <= w_commit;
            r_strobe <= w_tick;
            if (w_tick) begin
                r_anode <= w_next_idx;
                r_seg   <= w_seg_next;
                r_dp    <= w_dp_next;
            end
        end
    end

    // A load coinciding with a commit lands in pending for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pend_lzs <= 1'b0;
            r_sh_val   <= '0;
            r_sh_dp    <= '0;
            r_sh_lzs   <= 1'b0;
            r_sh_blank <= '1;
        end else begin
            if (bus.load) begin
                r_pend     <= 1'b1;
                r_pend_val <= bus.value;
                r_pend_dp  <= bus.dp_mask;
                r_pend_lzs <= bus.lzs;
            end else if (w_commit) begin
                r_pend <= 1'b0;
            end
            if (w_commit) begin
                r_sh_val   <= r_pend_val;
                r_sh_dp    <= r_pend_dp;
                r_sh_lzs   <= r_pend_lzs;
                r_sh_blank <= '0;
            end
        end
    end

    assign bus.load_ack     = r_ack;
    assign bus.anode_driver = r_anode;
    assign bus.seg          = r_seg;
    assign bus.dp           = r_dp;
    assign bus.digit_strobe = r_strobe;
endmodule
